// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder_pkg
// Shared types and constants for the data-memory responder slice.
// Revision: 1.0
// ============================================================================
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int c_ERR_W = 1;
  localparam int c_CNT_W = 4;

  // A single-word array still needs a one-bit index to form a legal vector.
  function automatic int idxWidth(input int depthWords);
    return (depthWords > 1) ? $clog2(depthWords) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder_if
// Request/response bundle between the MEM stage and the data-memory responder.
// Revision: 1.0
// ============================================================================
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [3:0]         req_be;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic [c_ERR_W-1:0] resp_err;
  logic               busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_bank.sv
`default_nettype none
// ============================================================================
// Module : dmem_bank
// Byte-enabled word array: synchronous write, combinational read.
// Revision: 1.0
// ============================================================================
module dmem_bank
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = r_mem[idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Data-memory responder with programmable wait-state latency and busy/stall.
// Revision: 1.0
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int                 c_IDX_W    = idxWidth(DEPTH_WORDS);
  localparam logic [32:0]        c_SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = (LATENCY > 0) ? c_CNT_W'(LATENCY - 1) : '0;

  state_t               r_state;
  state_t               w_nextState;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_nextCnt;
  logic                 w_accept;

  logic                 r_we;
  logic [3:0]           r_be;
  logic [31:0]          r_wdata;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_ERR_W-1:0]   r_err;

  logic [32:0]          w_offset;
  logic                 w_reqErr;
  logic                 w_inResp;
  logic                 w_bankWe;
  logic [31:0]          w_bankRdata;

  // 33-bit subtraction so an address below the base shows up as a borrow
  // instead of wrapping into the valid window.
  assign w_offset = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
  assign w_reqErr = (bus.req_addr[1:0] != 2'b00) || w_offset[32] || (w_offset >= c_SPAN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_be    <= bus.req_be;
        r_wdata <= bus.req_wdata;
        r_idx   <= bus.req_addr[c_IDX_W+1:2];
        r_err   <= c_ERR_W'(w_reqErr);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 0) begin
            w_nextState = RESP;
          end else begin
            w_nextState = WAIT;
            w_nextCnt   = c_CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_nextState = RESP;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Reset asserted in the response cycle kills both the pulse and the commit.
  assign w_inResp = (r_state == RESP) && !reset;
  assign w_bankWe = w_inResp && r_we && (r_err == '0);

  assign bus.req_ready  = (r_state == IDLE) && !reset;
  assign bus.busy       = (r_state != IDLE);
  assign bus.resp_valid = w_inResp;
  assign bus.resp_err   = w_inResp ? r_err : '0;
  assign bus.resp_rdata = (w_inResp && (r_err == '0) && !r_we) ? w_bankRdata : 32'h0;

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_IDX_W)
  ) u_bank (
    .clk   (clk),
    .we    (w_bankWe),
    .be    (r_be),
    .idx   (r_idx),
    .wdata (r_wdata),
    .rdata (w_bankRdata)
  );

endmodule
`default_nettype wire
